// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//  REG_COUNT : number of architectural registers (x0..x31)
//  ZERO_REG  : index of the hard-wired zero register, never written
//  state_t   : top-level sequencing state (zero-clear sweep, then arbitration)
package regfile_write_arbiter_pkg;

    localparam int REG_COUNT = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//  clk, reset : rising-edge clock, synchronous active-high reset
//  req[1:0]   : request vector (bit 0 = requester 0, bit 1 = requester 1)
//  enable     : when low no grant is issued and the pointer holds
//  grant[1:0] : one-hot (or zero) grant, combinational from req/enable/rr_ptr
// rr_ptr names the requester favoured on a tie; it moves to the other
// requester after every grant and holds on idle cycles.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic rr_ptr;

    // Grant selection: a lone request always wins, a tie goes to rr_ptr.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    // Fairness pointer: after granting requester 0 favour requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            rr_ptr <= grant[0];
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the single register-file write port.
// After reset it zero-clears x1..x31 (one register per cycle), then shares the
// port between the core writeback (req0) and a secondary writer (req1) with
// round-robin arbitration. All write-port outputs are registered.
//  clk, reset            : rising-edge clock, synchronous active-high reset
//  req0_valid/addr/data  : writeback request, req0_ready = accepted this cycle
//  req1_valid/addr/data  : secondary request, req1_ready = accepted this cycle
//  regwrite_o            : register-file write enable
//  write_register_o      : register-file write index
//  write_data_o          : register-file write data
//  busy_o                : zero-clear sweep in progress
//  grant_id_o            : requester owning the current write (0 during sweep)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  regwrite_o,
    output logic [ADDR_WIDTH-1:0] write_register_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  busy_o,
    output logic                  grant_id_o
);

    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR   = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX   = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic                  clear_last;
    logic                  arb_enable;
    logic [1:0]            grant;
    logic                  sel_valid;
    logic                  sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign clear_last = (clear_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the sweep ends on the cycle that issues the last index; arbitration is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: state_next = clear_last ? ST_ARB : ST_CLEAR;
            ST_ARB:   state_next = ST_ARB;
            default:  state_next = RESET_STATE;
        endcase
    end

    // State-decoded outputs: busy flag and arbiter enable.
    always_comb begin
        busy_o     = 1'b0;
        arb_enable = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy_o     = 1'b1;
                arb_enable = 1'b0;
            end
            ST_ARB: begin
                busy_o     = 1'b0;
                arb_enable = 1'b1;
            end
            default: begin
                busy_o     = 1'b0;
                arb_enable = 1'b0;
            end
        endcase
    end

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .enable (arb_enable),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Write mux: route the granted requester's address/data toward the output registers.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        sel_addr  = {ADDR_WIDTH{1'b0}};
        sel_data  = {DATA_WIDTH{1'b0}};
        case (grant)
            2'b01: begin
                sel_valid = 1'b1;
                sel_id    = 1'b0;
                sel_addr  = req0_addr;
                sel_data  = req0_data;
            end
            2'b10: begin
                sel_valid = 1'b1;
                sel_id    = 1'b1;
                sel_addr  = req1_addr;
                sel_data  = req1_data;
            end
            default: begin
                sel_valid = 1'b0;
                sel_id    = 1'b0;
                sel_addr  = {ADDR_WIDTH{1'b0}};
                sel_data  = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Sweep index: advances once per sweep cycle, restarts at x1 on every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_idx <= FIRST_IDX;
        end else if (state == ST_CLEAR) begin
            clear_idx <= clear_idx + FIRST_IDX;
        end else begin
            clear_idx <= clear_idx;
        end
    end

    // Write-port registers: sweep writes zero, arbitration writes the granted
    // request. A grant to x0 is consumed without asserting the write enable,
    // and index/data hold their last real value whenever no write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_o       <= 1'b0;
            write_register_o <= {ADDR_WIDTH{1'b0}};
            write_data_o     <= {DATA_WIDTH{1'b0}};
            grant_id_o       <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    regwrite_o       <= 1'b1;
                    write_register_o <= clear_idx;
                    write_data_o     <= {DATA_WIDTH{1'b0}};
                    grant_id_o       <= 1'b0;
                end
                ST_ARB: begin
                    if (sel_valid && (sel_addr != ZERO_ADDR)) begin
                        regwrite_o       <= 1'b1;
                        write_register_o <= sel_addr;
                        write_data_o     <= sel_data;
                        grant_id_o       <= sel_id;
                    end else if (sel_valid) begin
                        regwrite_o       <= 1'b0;
                        write_register_o <= write_register_o;
                        write_data_o     <= write_data_o;
                        grant_id_o       <= sel_id;
                    end else begin
                        regwrite_o       <= 1'b0;
                        write_register_o <= write_register_o;
                        write_data_o     <= write_data_o;
                        grant_id_o       <= grant_id_o;
                    end
                end
                default: begin
                    regwrite_o       <= 1'b0;
                    write_register_o <= write_register_o;
                    write_data_o     <= write_data_o;
                    grant_id_o       <= grant_id_o;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: one instance with the zero-clear sweep and
// one without, both compared every cycle against a transaction-level model
// (sweep counter, tie-break favourite, expected write, shadow register file).
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Index 0: CLEAR_ON_RESET=1 instance, index 1: CLEAR_ON_RESET=0 instance.
    logic          r0v [2];
    logic [AW-1:0] r0a [2];
    logic [DW-1:0] r0d [2];
    logic          r1v [2];
    logic [AW-1:0] r1a [2];
    logic [DW-1:0] r1d [2];
    logic          r0rdy [2];
    logic          r1rdy [2];
    logic          we [2];
    logic [AW-1:0] wr [2];
    logic [DW-1:0] wd [2];
    logic          busy [2];
    logic          gid [2];

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) u_dut_clr (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[0]), .req0_addr(r0a[0]), .req0_data(r0d[0]), .req0_ready(r0rdy[0]),
        .req1_valid(r1v[0]), .req1_addr(r1a[0]), .req1_data(r1d[0]), .req1_ready(r1rdy[0]),
        .regwrite_o(we[0]), .write_register_o(wr[0]), .write_data_o(wd[0]),
        .busy_o(busy[0]), .grant_id_o(gid[0])
    );

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) u_dut_noclr (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[1]), .req0_addr(r0a[1]), .req0_data(r0d[1]), .req0_ready(r0rdy[1]),
        .req1_valid(r1v[1]), .req1_addr(r1a[1]), .req1_data(r1d[1]), .req1_ready(r1rdy[1]),
        .regwrite_o(we[1]), .write_register_o(wr[1]), .write_data_o(wd[1]),
        .busy_o(busy[1]), .grant_id_o(gid[1])
    );

    // Pending stimulus per instance (applied at the falling edge).
    bit          p0v [2];
    int          p0a [2];
    logic [31:0] p0d [2];
    bit          p1v [2];
    int          p1a [2];
    logic [31:0] p1d [2];
    bit          acc0 [2];
    bit          acc1 [2];

    // Reference model state.
    int          clear_left [2];
    int          next_clear [2];
    int          favour [2];
    bit          e_we [2];
    int          e_gid [2];
    bit          hold_ok [2];
    int          last_wr [2];
    logic [31:0] last_wd [2];
    logic [31:0] ref_rf [2][32];
    logic [31:0] obs_rf [2][32];

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        clear_left[d] = (d == 0) ? 31 : 0;
        next_clear[d] = 1;
        favour[d]     = 0;
        e_we[d]       = 1'b0;
        e_gid[d]      = 0;
        hold_ok[d]    = 1'b1;
        last_wr[d]    = 0;
        last_wd[d]    = 32'h0;
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic cycle(input bit rst);
        int g;
        int a;
        logic [31:0] dat;
        @(negedge clk);
        reset = rst;
        for (int d = 0; d < 2; d++) begin
            r0v[d] = p0v[d]; r0a[d] = AW'(p0a[d]); r0d[d] = p0d[d];
            r1v[d] = p1v[d]; r1a[d] = AW'(p1a[d]); r1d[d] = p1d[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            acc0[d] = 1'b0;
            acc1[d] = 1'b0;
            if (rst) begin
                model_reset(d);
            end else begin
                g = -1;
                if (clear_left[d] == 0) begin
                    if (p0v[d] && p1v[d]) g = favour[d];
                    else if (p0v[d])      g = 0;
                    else if (p1v[d])      g = 1;
                end
                check_val($sformatf("d%0d req0_ready", d), {31'h0, r0rdy[d]}, (g == 0) ? 32'h1 : 32'h0);
                check_val($sformatf("d%0d req1_ready", d), {31'h0, r1rdy[d]}, (g == 1) ? 32'h1 : 32'h0);
                acc0[d] = (g == 0);
                acc1[d] = (g == 1);
                if (clear_left[d] > 0) begin
                    e_we[d]    = 1'b1;
                    e_gid[d]   = 0;
                    last_wr[d] = next_clear[d];
                    last_wd[d] = 32'h0;
                    hold_ok[d] = 1'b1;
                    ref_rf[d][next_clear[d]] = 32'h0;
                    next_clear[d]++;
                    clear_left[d]--;
                end else if (g >= 0) begin
                    favour[d] = 1 - g;
                    a   = (g == 1) ? p1a[d] : p0a[d];
                    dat = (g == 1) ? p1d[d] : p0d[d];
                    e_gid[d] = g;
                    if (a != 0) begin
                        e_we[d]    = 1'b1;
                        last_wr[d] = a;
                        last_wd[d] = dat;
                        hold_ok[d] = 1'b1;
                        ref_rf[d][a] = dat;
                    end else begin
                        e_we[d]    = 1'b0;
                        hold_ok[d] = 1'b0;
                    end
                end else begin
                    e_we[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("d%0d regwrite", d), {31'h0, we[d]}, {31'h0, e_we[d]});
            check_val($sformatf("d%0d busy", d), {31'h0, busy[d]}, (clear_left[d] > 0) ? 32'h1 : 32'h0);
            if (e_we[d] || hold_ok[d]) begin
                check_val($sformatf("d%0d write_register", d), {27'h0, wr[d]}, 32'(last_wr[d]));
                check_val($sformatf("d%0d write_data", d), wd[d], last_wd[d]);
            end
            if (e_we[d] || rst) begin
                check_val($sformatf("d%0d grant_id", d), {31'h0, gid[d]}, 32'(e_gid[d]));
            end
            if (we[d] === 1'b1) obs_rf[d][wr[d]] = wd[d];
        end
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(0, 31));
    endfunction

    // Random requester behaviour: keep an unaccepted request stable, occasionally withdraw it.
    task automatic update_random();
        for (int d = 0; d < 2; d++) begin
            if (!p0v[d] || acc0[d]) begin
                p0v[d] = ($urandom_range(0, 99) < 70);
                p0a[d] = rand_addr();
                p0d[d] = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                p0v[d] = 1'b0;
            end
            if (!p1v[d] || acc1[d]) begin
                p1v[d] = ($urandom_range(0, 99) < 70);
                p1a[d] = rand_addr();
                p1d[d] = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                p1v[d] = 1'b0;
            end
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            p0v[d] = 1'b0; p0a[d] = 0; p0d[d] = 32'h0;
            p1v[d] = 1'b0; p1a[d] = 0; p1d[d] = 32'h0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                ref_rf[d][r] = 32'h0;
                obs_rf[d][r] = 32'h0;
            end
        end
        idle_all();

        // Reset for two cycles.
        cycle(1'b1);
        cycle(1'b1);

        // Sweep with req0 pending on the clearing instance; the non-clearing
        // instance accepts a write on its first cycle out of reset.
        p0v[0] = 1'b1; p0a[0] = 9;  p0d[0] = 32'h0000_0909;
        p0v[1] = 1'b1; p0a[1] = 31; p0d[1] = 32'hCAFE_F00D;
        cycle(1'b0);
        p0v[1] = 1'b0;
        for (int i = 0; i < 31; i++) cycle(1'b0);
        p0v[0] = 1'b0;

        // Single writeback request.
        p0v[0] = 1'b1; p0a[0] = 5; p0d[0] = 32'hDEAD_BEEF;
        cycle(1'b0);
        idle_all();
        cycle(1'b0);

        // Both requesters busy every cycle: grants alternate.
        p0v[0] = 1'b1; p0a[0] = 3; p0d[0] = 32'h0000_0003;
        p1v[0] = 1'b1; p1a[0] = 4; p1d[0] = 32'h0000_0004;
        for (int i = 0; i < 8; i++) cycle(1'b0);
        idle_all();

        // Secondary writer targeting x0.
        p1v[0] = 1'b1; p1a[0] = 0; p1d[0] = 32'h0000_1234;
        cycle(1'b0);
        idle_all();
        cycle(1'b0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            update_random();
            cycle(1'b0);
        end

        // Reset in the middle of the sweep (after x1..x16 issued).
        idle_all();
        cycle(1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0);
        cycle(1'b1);
        for (int i = 0; i < 200; i++) begin
            update_random();
            cycle(1'b0);
        end
        idle_all();
        cycle(1'b0);

        // Final register-file images must match (last writer wins).
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                check_val($sformatf("d%0d rf x%0d", d, r), obs_rf[d][r], ref_rf[d][r]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
